// File: rtl/reg_bank_responder.sv
`timescale 1ns/1ps
// reg_bank_responder: R-tile register bank with a staged 32-slot write queue,
// forwarding reads, block commit drain and flush.
module reg_bank_responder #(
   parameter int DATA_W    = 64,
   parameter int NUM_BANKS = 4,
   parameter int BANK_ID   = 0,
   parameter int NUM_WQ    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_req,
   input  logic              write_req,
   input  logic [6:0]        reg_id,
   input  logic [4:0]        queue_id,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              ack,
   output logic              alignment_err,
   input  logic              commit_req,
   input  logic              flush,
   output logic              commit_done,
   output logic              busy
);
   localparam int NREG = 128 / NUM_BANKS;
   typedef enum logic [1:0] {IDLE, RESP, COMMIT} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [NUM_WQ-1:0] wv_q, wv_d;
   logic [4:0]        wl_q [NUM_WQ];
   logic [4:0]        wl_d [NUM_WQ];
   logic [DATA_W-1:0] wd_q [NUM_WQ];
   logic [DATA_W-1:0] wd_d [NUM_WQ];
   logic [4:0]        idx_q, idx_d;
   logic              ack_q, ack_d, err_q, err_d, done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, fwd_data;
   logic              fwd_hit, aligned;
   logic [4:0]        li;
   assign li            = reg_id[6:2];
   assign aligned       = reg_id[1:0] == BANK_ID[1:0] && !(read_req && write_req);
   assign read_data     = rdata_q;
   assign ack           = ack_q;
   assign alignment_err = err_q;
   assign commit_done   = done_q;
   assign busy          = state_q == COMMIT;
   // later (higher-index) matches override earlier ones
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < NUM_WQ; i++)
         if (wv_q[i] && wl_q[i] == li) begin
            fwd_hit  = 1'b1;
            fwd_data = wd_q[i];
         end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rf_d    = rf_q;
      wv_d    = wv_q;
      wl_d    = wl_q;
      wd_d    = wd_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (flush) wv_d = '0;
            else if (commit_req) begin
               state_d = COMMIT;
               idx_d   = '0;
            end else if (read_req || write_req) begin
               state_d = RESP;
               ack_d   = 1'b1;
               err_d   = !aligned;
               rdata_d = (aligned && read_req) ? (fwd_hit ? fwd_data : rf_q[li]) : '0;
               if (aligned && write_req) begin
                  wv_d[queue_id] = 1'b1;
                  wl_d[queue_id] = li;
                  wd_d[queue_id] = write_data;
               end
            end
         end
         RESP: state_d = IDLE;
         COMMIT: begin
            if (flush) begin
               wv_d    = '0;
               state_d = IDLE;
            end else begin
               if (wv_q[idx_q]) begin
                  rf_d[wl_q[idx_q]] = wd_q[idx_q];
                  wv_d[idx_q]       = 1'b0;
               end
               idx_d = idx_q + 5'd1;
               if (idx_q == 5'(NUM_WQ - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rf_q    <= '{default: '0};
         wv_q    <= '0;
         wl_q    <= '{default: '0};
         wd_q    <= '{default: '0};
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rf_q    <= rf_d;
         wv_q    <= wv_d;
         wl_q    <= wl_d;
         wd_q    <= wd_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_reg_bank_responder.sv
`timescale 1ns/1ps
// tb_reg_bank_responder: directed vectors for bank 1; expected responses are
// queued by the stimulus and checked by an independent ack monitor.
module tb_reg_bank_responder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        read_req = 1'b0, write_req = 1'b0, commit_req = 1'b0, flush = 1'b0;
   logic [6:0]  reg_id = '0;
   logic [4:0]  queue_id = '0;
   logic [63:0] write_data = '0, read_data;
   logic        ack, alignment_err, commit_done, busy;
   int          compared = 0, failed = 0;
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   reg_bank_responder #(.DATA_W(64), .NUM_BANKS(4), .BANK_ID(1), .NUM_WQ(32)) dut (
      .clk(clk), .rst_n(rst_n), .read_req(read_req), .write_req(write_req),
      .reg_id(reg_id), .queue_id(queue_id), .write_data(write_data),
      .read_data(read_data), .ack(ack), .alignment_err(alignment_err),
      .commit_req(commit_req), .flush(flush), .commit_done(commit_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ack) begin
         compared++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_ack err=%0b data=%h", alignment_err, read_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({alignment_err, read_data} !== mon_e) begin
               failed++;
               $display("FAIL response got err=%0b data=%h want err=%0b data=%h",
                        alignment_err, read_data, mon_e[64], mon_e[63:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      compared++;
      if (got !== want) begin
         failed++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic req(input logic rd, input logic wr, input logic [6:0] id, input logic [4:0] q,
                      input logic [63:0] d, input logic e, input logic [63:0] x, input int lat);
      int n = 0;
      exp_q.push_back({e, x});
      @(posedge clk); #1;
      read_req = rd; write_req = wr; reg_id = id; queue_id = q; write_data = d;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 100);
      check($sformatf("latency_id%0d", id), 128'(n), 128'(lat));
      @(posedge clk); #1;
      read_req = 1'b0; write_req = 1'b0;
   endtask

   task automatic pulse_commit();
      @(posedge clk); #1 commit_req = 1'b1;
      @(posedge clk); #1 commit_req = 1'b0;
   endtask

   task automatic commit_run();
      int n = 0;
      pulse_commit();
      do begin
         @(negedge clk);
         if (busy) n++;
      end while (busy && n < 100);
      check("busy_cycles", 128'(n), 128'd32);
      check("commit_done", 128'(commit_done), 128'd1);
   endtask

   task automatic pulse_flush();
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 check("reset_outputs", {ack, alignment_err, busy, commit_done, read_data}, '0);
      rst_n = 1'b1;
      // forwarding from the queue while the file still holds 0
      req(0, 1, 7'd5, 5'd3, 64'hAB, 0, 64'h0, 2);
      req(1, 0, 7'd5, 5'd0, 64'h0, 0, 64'hAB, 2);
      req(1, 0, 7'd6, 5'd0, 64'h0, 1, 64'h0, 2);
      req(1, 0, 7'd5, 5'd0, 64'h0, 0, 64'hAB, 2);
      // duplicates to G9; a misaligned write to G8 must not land in the queue
      req(0, 1, 7'd9, 5'd2, 64'h11, 0, 64'h0, 2);
      req(0, 1, 7'd9, 5'd7, 64'h22, 0, 64'h0, 2);
      req(0, 1, 7'd8, 5'd9, 64'h66, 1, 64'h0, 2);
      req(1, 0, 7'd9, 5'd0, 64'h0, 0, 64'h22, 2);
      commit_run();
      req(1, 0, 7'd9, 5'd0, 64'h0, 0, 64'h22, 2);
      req(1, 0, 7'd5, 5'd0, 64'h0, 0, 64'hAB, 2);
      // slot index, not write order, decides the winner
      req(0, 1, 7'd9, 5'd7, 64'h33, 0, 64'h0, 2);
      req(0, 1, 7'd9, 5'd2, 64'h44, 0, 64'h0, 2);
      req(1, 0, 7'd9, 5'd0, 64'h0, 0, 64'h33, 2);
      commit_run();
      req(1, 0, 7'd9, 5'd0, 64'h0, 0, 64'h33, 2);
      // flush in IDLE discards the queue
      req(0, 1, 7'd13, 5'd0, 64'h55, 0, 64'h0, 2);
      pulse_flush();
      req(1, 0, 7'd13, 5'd0, 64'h0, 0, 64'h0, 2);
      commit_run();
      req(1, 0, 7'd13, 5'd0, 64'h0, 0, 64'h0, 2);
      // read and write together are rejected and leave the queue alone
      req(1, 1, 7'd21, 5'd5, 64'h99, 1, 64'h0, 2);
      req(1, 0, 7'd21, 5'd0, 64'h0, 0, 64'h0, 2);
      // request stalled by a drain
      req(0, 1, 7'd25, 5'd1, 64'hC3, 0, 64'h0, 2);
      pulse_commit();
      req(1, 0, 7'd25, 5'd0, 64'h0, 0, 64'hC3, 33);
      // flush mid-drain: slot 0 already drained, slot 31 discarded
      req(0, 1, 7'd29, 5'd31, 64'hEE, 0, 64'h0, 2);
      req(0, 1, 7'd33, 5'd0, 64'h5A, 0, 64'h0, 2);
      pulse_commit();
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk) check("abort_idle", {busy, commit_done}, '0);
      @(negedge clk) check("abort_no_done", {busy, commit_done}, '0);
      req(1, 0, 7'd33, 5'd0, 64'h0, 0, 64'h5A, 2);
      req(1, 0, 7'd29, 5'd0, 64'h0, 0, 64'h0, 2);
      // asynchronous reset in the middle of a drain
      req(0, 1, 7'd17, 5'd4, 64'h77, 0, 64'h0, 2);
      pulse_commit();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("reset_mid_commit", {ack, alignment_err, busy, commit_done, read_data}, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      req(1, 0, 7'd17, 5'd0, 64'h0, 0, 64'h0, 2);
      req(1, 0, 7'd9, 5'd0, 64'h0, 0, 64'h0, 2);
      repeat (3) @(posedge clk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
